// File: rtl/add_serial.sv
// add_serial: digit-serial adder/subtractor with a valid/ready handshake on
// both sides. An operation is latched in IDLE, processed one DIGIT-wide slice
// per clock (LSB slice first) in BUSY, and held in DONE until the consumer
// takes it.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands and mode present
//   in_ready   block can accept an operation (IDLE only)
//   a, b       WIDTH-bit operands
//   ci         carry in (add) / borrow in (sub)
//   mode       0 = add, 1 = subtract
//   out_valid  result held on s/co/ov (DONE only)
//   out_ready  consumer takes result
//   s          sum/difference mod 2^WIDTH
//   co         add: carry out; sub: 1 = no borrow
//   ov         two's-complement signed overflow
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready = 1
// BUSY  | adding one digit slice per edge, carry rippling through cy
// DONE  | result held, out_valid = 1 until out_ready
module add_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;      // already inverted for subtract
    logic             cy;       // carry rippling between slices
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] s_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        a_dig  = '0;
        b_dig  = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
                a_dig = opa[i*DIGIT +: DIGIT];
                b_dig = opb[i*DIGIT +: DIGIT];
            end
        end
        sum    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cy};
        s_next = s;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
                s_next[i*DIGIT +: DIGIT] = sum[DIGIT-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            cy    <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= mode ? ~b : b;
                        // subtract is a + ~b + ~ci
                        cy    <= ci ^ mode;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    s  <= s_next;
                    cy <= sum[DIGIT];
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        co    <= sum[DIGIT];
                        // final slice carries the result MSB
                        ov    <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                                 (sum[DIGIT-1] != opa[WIDTH-1]);
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
